// File: rtl/semaforo_pkg.sv
// Shared state codes and output-bit positions for the car/pedestrian traffic-light controller.
package semaforo_pkg;

  localparam logic [2:0] VERDE_CARRO  = 3'b000;
  localparam logic [2:0] AMARELO      = 3'b001;
  localparam logic [2:0] INDEF        = 3'b010;
  localparam logic [2:0] VERMELHO_SEG = 3'b011;
  localparam logic [2:0] VERDE_PED    = 3'b100;
  localparam logic [2:0] PISCA_PED    = 3'b101;

  localparam int unsigned SAIDA_CARRO_VERM  = 4;
  localparam int unsigned SAIDA_CARRO_AMAR  = 3;
  localparam int unsigned SAIDA_CARRO_VERDE = 2;
  localparam int unsigned SAIDA_PED_VERM    = 1;
  localparam int unsigned SAIDA_PED_VERDE   = 0;

endpackage

// File: rtl/semaforo_ped_ctrl_if.sv
// Control/status bundle of the traffic-light controller; master drives the inputs.
interface semaforo_ped_ctrl_if;
  logic       tick;
  logic       modo_piscante;
  logic       botao_ped;
  logic [2:0] estado;
  logic [4:0] saida;
  logic       pedido_pend;

  modport master (
    output tick, modo_piscante, botao_ped,
    input  estado, saida, pedido_pend
  );

  modport slave (
    input  tick, modo_piscante, botao_ped,
    output estado, saida, pedido_pend
  );
endinterface

// File: rtl/contador_fase.sv
// Phase-duration counter: advances on tick, wraps at limite-1 and flags the terminal tick.
module contador_fase #(
  parameter int unsigned LARG_CONT = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic                 clr,
  input  logic [LARG_CONT-1:0] limite,
  output logic [LARG_CONT-1:0] cont,
  output logic                 fim
);

  assign fim = tick && (cont == limite - LARG_CONT'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cont <= '0;
    end else if (clr) begin
      cont <= '0;
    end else if (tick) begin
      cont <= fim ? '0 : cont + 1'b1;
    end
  end

endmodule

// File: rtl/semaforo_ped_ctrl.sv
// Vehicle/pedestrian traffic-light FSM with latched ped request and flashing maintenance mode.
// Optional SEMAFORO_SOB_DEMANDA_EN: car green holds until a pedestrian request is pending.
module semaforo_ped_ctrl
  import semaforo_pkg::*;
#(
  parameter int unsigned LARG_CONT = 8,
  parameter int unsigned T_VERDE   = 6,
  parameter int unsigned T_AMARELO = 2,
  parameter int unsigned T_SEG     = 1,
  parameter int unsigned T_PED     = 4,
  parameter int unsigned T_PISCA   = 6
) (
  input logic                clk,
  input logic                rst,
  semaforo_ped_ctrl_if.slave bus
);

  logic [2:0]           estado_q, estado_d;
  logic                 pisca_q, pisca_d;
  logic                 pedido_q, pedido_d;
  logic [LARG_CONT-1:0] cont, limite;
  logic                 fim, clr, espera, tick_cnt;

`ifdef SEMAFORO_SOB_DEMANDA_EN
  // Gating the counter's tick saturates cont at T_VERDE-1 until a request is pending.
  assign espera = (estado_q == VERDE_CARRO) && !pedido_q &&
                  (cont == LARG_CONT'(T_VERDE - 1));
`else
  assign espera = 1'b0;
`endif

  assign tick_cnt = bus.tick && !espera;
  assign clr = bus.modo_piscante ||
               !(estado_q inside {VERDE_CARRO, AMARELO, VERMELHO_SEG, VERDE_PED, PISCA_PED});

  always_comb begin
    limite = LARG_CONT'(T_VERDE);
    case (estado_q)
      AMARELO:      limite = LARG_CONT'(T_AMARELO);
      VERMELHO_SEG: limite = LARG_CONT'(T_SEG);
      VERDE_PED:    limite = LARG_CONT'(T_PED);
      PISCA_PED:    limite = LARG_CONT'(T_PISCA);
      default:      ;
    endcase
  end

  contador_fase #(
    .LARG_CONT (LARG_CONT)
  ) u_contador_fase (
    .clk    (clk),
    .rst    (rst),
    .tick   (tick_cnt),
    .clr    (clr),
    .limite (limite),
    .cont   (cont),
    .fim    (fim)
  );

  always_comb begin
    estado_d = estado_q;
    if (bus.modo_piscante) begin
      estado_d = INDEF;
    end else begin
      case (estado_q)
        VERDE_CARRO:  if (fim) estado_d = AMARELO;
        AMARELO:      if (fim) estado_d = VERMELHO_SEG;
        VERMELHO_SEG: if (fim) estado_d = VERDE_PED;
        VERDE_PED:    if (fim) estado_d = PISCA_PED;
        PISCA_PED:    if (fim) estado_d = VERDE_CARRO;
        INDEF:        estado_d = VERDE_CARRO;
        default:      estado_d = INDEF;
      endcase
    end
  end

  always_comb begin
    pisca_d = pisca_q;
    if ((estado_d != estado_q) && (estado_d == PISCA_PED || estado_d == INDEF)) begin
      pisca_d = 1'b1;
    end else if (bus.tick && (estado_q == PISCA_PED || estado_q == INDEF)) begin
      pisca_d = ~pisca_q;
    end
  end

  // Clearing on VERDE_PED entry takes priority over a press on the same edge.
  always_comb begin
    pedido_d = pedido_q;
    if (estado_d == VERDE_PED && estado_q != VERDE_PED) begin
      pedido_d = 1'b0;
    end else if (bus.botao_ped && estado_d != VERDE_PED) begin
      pedido_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado_q <= VERDE_CARRO;
      pisca_q  <= 1'b1;
      pedido_q <= 1'b0;
    end else begin
      estado_q <= estado_d;
      pisca_q  <= pisca_d;
      pedido_q <= pedido_d;
    end
  end

  always_comb begin
    bus.saida = '0;
    case (estado_q)
      VERDE_CARRO: begin
        bus.saida[SAIDA_CARRO_VERDE] = 1'b1;
        bus.saida[SAIDA_PED_VERM]    = 1'b1;
      end
      AMARELO: begin
        bus.saida[SAIDA_CARRO_AMAR] = 1'b1;
        bus.saida[SAIDA_PED_VERM]   = 1'b1;
      end
      VERMELHO_SEG: begin
        bus.saida[SAIDA_CARRO_VERM] = 1'b1;
        bus.saida[SAIDA_PED_VERM]   = 1'b1;
      end
      VERDE_PED: begin
        bus.saida[SAIDA_CARRO_VERM] = 1'b1;
        bus.saida[SAIDA_PED_VERDE]  = 1'b1;
      end
      PISCA_PED: begin
        bus.saida[SAIDA_CARRO_VERM] = 1'b1;
        bus.saida[SAIDA_PED_VERM]   = pisca_q;
      end
      INDEF:   bus.saida[SAIDA_CARRO_AMAR] = pisca_q;
      default: ;
    endcase
  end

  assign bus.estado      = estado_q;
  assign bus.pedido_pend = pedido_q;

endmodule
